// File: rtl/imem_load_ctrl.sv
// Run controller: loads a length-prefixed program into instruction memory,
// releases the core and watches for HALT under a watchdog cycle budget.
module imem_load_ctrl #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_rst_n,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [15:0]       run_cycles
);

  // state | meaning
  // IDLE  | waiting for a length byte
  // LOAD  | accepting program bytes, one write per accepted byte
  // START | last write lands while the core is still held in reset
  // RUN   | core released, watchdog counting
  // DONE  | core halted; one cycle back in reset before IDLE
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   r_len;
  logic              r_host_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_core_rst_n;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_err;
  logic [15:0]       r_run_cycles;

  logic              w_acc;
  logic              w_len_ok;
  logic              w_timeout;
  logic [ADDR_W:0]   w_cnt_inc;

  assign w_acc     = host_valid && r_host_ready;
  assign w_len_ok  = (host_data != 8'd0) && ({24'd0, host_data} <= 32'(DEPTH));
  assign w_timeout = (TIMEOUT != 0) && (r_run_cycles == TO_LAST);
  assign w_cnt_inc = r_cnt + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_host_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'd0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 2'b00;
      r_run_cycles <= 16'd0;
    end else begin
      r_mem_we <= 1'b0;
      if (abort) begin
        r_state      <= IDLE;
        r_host_ready <= 1'b1;
        r_core_rst_n <= 1'b0;
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
        r_err        <= 2'b00;
      end else begin
        case (r_state)
          IDLE: begin
            r_host_ready <= 1'b1;
            if (w_acc) begin
              if (w_len_ok) begin
                r_len   <= host_data[ADDR_W:0];
                r_cnt   <= '0;
                r_done  <= 1'b0;
                r_err   <= 2'b00;
                r_busy  <= 1'b1;
                r_state <= LOAD;
              end else begin
                r_err <= 2'b01;
              end
            end
          end
          LOAD: begin
            if (w_acc) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_cnt[ADDR_W-1:0];
              r_mem_wdata <= host_data;
              r_cnt       <= w_cnt_inc;
              if (w_cnt_inc == r_len) begin
                r_host_ready <= 1'b0;
                r_state      <= START;
              end
            end
          end
          START: begin
            r_run_cycles <= 16'd0;
            r_core_rst_n <= 1'b1;
            r_state      <= RUN;
          end
          RUN: begin
            if (r_run_cycles != 16'hFFFF)
              r_run_cycles <= r_run_cycles + 16'd1;
            // halt takes precedence over a watchdog expiring in the same cycle
            if (core_halted) begin
              r_done       <= 1'b1;
              r_core_rst_n <= 1'b0;
              r_busy       <= 1'b0;
              r_state      <= DONE;
            end else if (w_timeout) begin
              r_err        <= 2'b10;
              r_core_rst_n <= 1'b0;
              r_busy       <= 1'b0;
              r_host_ready <= 1'b1;
              r_state      <= IDLE;
            end
          end
          DONE: begin
            r_host_ready <= 1'b1;
            r_state      <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign host_ready = r_host_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_rst_n = r_core_rst_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign run_cycles = r_run_cycles;

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Run controller for the 8-bit accumulator core.
- Accepts a length-prefixed program byte stream from the host over a valid/ready handshake and writes it into the 128-byte instruction memory at addresses 0..N-1.
- Holds the core in reset during the load, then releases it and monitors for HALT under a watchdog cycle budget.
- Reports completion, error cause and the run-cycle count to the pad-level wrapper.

Parameters:
- DEPTH, 128, instruction memory depth in bytes; also the maximum legal program length.
- ADDR_W, 7, memory address width; DEPTH = 2^ADDR_W.
- TIMEOUT, 4096, maximum RUN cycles before abort; 0 disables the watchdog; must be < 65536.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- host_valid  in  1  host byte valid.
- host_data  in  8  host byte: length byte first, then program bytes.
- host_ready  out  1  controller accepts host_data this cycle.
- abort  in  1  synchronous abort; highest priority.
- mem_we  out  1  instruction memory write enable (registered).
- mem_addr  out  ADDR_W  write address (registered).
- mem_wdata  out  8  write data (registered).
- core_rst_n  out  1  core reset, active-low (registered).
- core_halted  in  1  core is in its HALT state.
- busy  out  1  high in LOAD, START, RUN.
- done  out  1  sticky: the last run reached HALT.
- err  out  2  sticky: 00 none, 01 bad length, 10 watchdog timeout.
- run_cycles  out  16  RUN cycles of the last run; frozen outside RUN.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - host_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0.
  - busy=0, done=0, err=00, run_cycles=0.
  - host_ready rises on the first clock after reset is released.
- Handshake: a byte is accepted when host_valid and host_ready are both 1 on a rising edge. host_data is ignored when host_ready=0.
- host_ready=1 only in IDLE and LOAD.
- core_rst_n=1 only in RUN; it is 0 in every other state.
- IDLE:
  - Accepted byte L is the program length.
  - If 1 <= L <= DEPTH: store L, clear the load counter, clear done and err, go to LOAD.
  - If L=0 or L>DEPTH: set err=01, stay in IDLE.
- LOAD:
  - Each accepted byte is written on the next cycle: mem_we=1, mem_addr=counter, mem_wdata=byte. Single-cycle pulse per byte.
  - Counter increments per accepted byte.
  - When the L-th byte is accepted, go to START; host_ready drops the cycle after.
  - Back-to-back bytes give one write per cycle with no bubbles.
- START:
  - One cycle; lets the final write land while the core is still held in reset.
  - Clears run_cycles, then goes to RUN.
- RUN:
  - core_rst_n=1.
  - run_cycles increments each cycle and saturates at 0xFFFF.
  - If core_halted=1: go to DONE and set done=1.
  - Else if TIMEOUT != 0 and run_cycles == TIMEOUT-1: go to IDLE, set err=10, and reassert core_rst_n=0 next cycle.
  - If halt and timeout occur in the same cycle, halt wins (DONE, err stays 00).
- DONE:
  - One cycle with core_rst_n=0, then go to IDLE.
  - done stays 1 until the next valid length byte or an abort.
- abort=1 in any state:
  - Next state IDLE, core_rst_n=0, mem_we=0, done=0, err=00.
  - Beats a simultaneous handshake or halt; an abort-cycle byte is not written even if accepted.
  - Memory contents after a partial load are undefined.
- Reset mid-operation: a pending write is dropped and all state follows the reset values above.
- Latency: length byte accepted at cycle t; the last of N bytes is accepted no earlier than t+N and written at t+N+1; START at t+N+1; core released at t+N+2.
- Address wrap: with L <= DEPTH, mem_addr never wraps; the counter is ADDR_W+1 bits wide internally.

Test Plan:
- Reset, then stream 0x04, 0x01, 0x05, 0x0A, 0x00 with valid held high -> four mem_we pulses at addresses 0..3 with data 01,05,0A,00; core_rst_n rises 2 cycles after the last byte; the core model asserts halted after 6 cycles -> done=1, err=00, run_cycles=6.
- Length byte 0x00, then separately 0x81 -> err=01 each time, state stays IDLE, no mem_we; a following length 0x02 clears err.
- TIMEOUT=16, load a 2-byte program, core never halts -> exactly 16 RUN cycles, then err=10, core_rst_n=0, host_ready=1.
- Toggle host_valid every other cycle during a 3-byte load -> exactly 3 writes at addresses 0,1,2; no write on idle cycles.
- Assert abort mid-LOAD after 2 of 5 bytes -> IDLE next cycle, no further writes, busy=0; a new load of 1 byte succeeds.
- Assert core_halted on the same cycle the watchdog expires -> done=1, err=00.
